// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between an instruction fetch
// requester (IF) and a load/store requester (MEM).
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   rdy                  global enable, 0 pauses the whole block
//   if_req/if_addr       fetch request (always 4 bytes), held until if_done
//   if_done/if_data      one-cycle completion pulse and fetched word
//   mem_req/mem_we/mem_size/mem_addr/mem_wdata
//                        load/store request, held until mem_done
//   mem_done/mem_rdata   one-cycle completion pulse and zero-extended load data
//   ram_din              RAM read byte, valid one cycle after ram_addr
//   ram_addr/ram_dout/ram_wr  registered RAM address, write byte, write strobe
//   busy                 high whenever the FSM is not idle
//
// Handshake: a requester raises req with stable request fields and keeps them
// until its done pulse. Requests are sampled only in IDLE with rdy=1; the
// granted request is copied internally, so later changes on the request
// inputs have no effect on the transfer in flight. done is a single-cycle
// pulse delivered in the DONE state on a cycle with rdy=1.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        ram_wr,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Counter wide enough to hold STARVE_LIMIT (and at least one bit).
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [1:0]    state;
    logic          own_mem;     // 1 = MEM owns the current transfer
    logic [2:0]    nbytes;      // 1, 2 or 4
    logic [2:0]    k;           // byte index
    logic [23:0]   wdata_rest;  // store bytes not yet placed on ram_dout
    logic [31:0]   buf_q;       // read assembly buffer
    logic          pend;        // ram_din this cycle belongs to lane pend_lane
    logic [1:0]    pend_lane;
    logic [CW-1:0] starve_cnt;
    logic          ram_wr_q;

    logic          grant_if;
    logic          grant_mem;
    logic [2:0]    mem_n;
    logic [31:0]   buf_next;

    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (state == S_IDLE && rdy) begin
            if (if_req && mem_req) begin
                if (starve_cnt == LIMIT) grant_if = 1'b1;
                else                     grant_mem = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end else if (mem_req) begin
                grant_mem = 1'b1;
            end
        end
    end

    always_comb begin
        case (mem_size)
            2'b00:   mem_n = 3'd1;
            2'b01:   mem_n = 3'd2;
            default: mem_n = 3'd4;
        endcase
    end

    // Buffer with the byte currently arriving on ram_din merged in, so the
    // final byte can go straight to the owner's data output.
    always_comb begin
        buf_next = buf_q;
        if (pend) buf_next[{pend_lane, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            own_mem    <= 1'b0;
            nbytes     <= 3'd0;
            k          <= 3'd0;
            wdata_rest <= 24'd0;
            buf_q      <= 32'd0;
            pend       <= 1'b0;
            pend_lane  <= 2'd0;
            starve_cnt <= '0;
            ram_wr_q   <= 1'b0;
            ram_addr   <= 32'd0;
            ram_dout   <= 8'd0;
            if_data    <= 32'd0;
            mem_rdata  <= 32'd0;
        end else begin
            // A byte requested on an earlier cycle is captured even while
            // paused; a new byte is only outstanding if this cycle advanced.
            if (state == S_RD) begin
                buf_q     <= buf_next;
                pend      <= rdy && (k < nbytes);
                pend_lane <= k[1:0];
            end
            if (rdy) begin
                case (state)
                    S_IDLE: begin
                        if (grant_if || grant_mem) begin
                            own_mem <= grant_mem;
                            k       <= 3'd0;
                            buf_q   <= 32'd0;
                            pend    <= 1'b0;
                            if (grant_if) begin
                                nbytes     <= 3'd4;
                                ram_addr   <= if_addr;
                                starve_cnt <= '0;
                                state      <= S_RD;
                            end else begin
                                nbytes     <= mem_n;
                                ram_addr   <= mem_addr;
                                ram_dout   <= mem_wdata[7:0];
                                wdata_rest <= mem_wdata[31:8];
                                if (!if_req)                 starve_cnt <= '0;
                                else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CW'(1);
                                if (mem_we) begin
                                    ram_wr_q <= 1'b1;
                                    state    <= S_WR;
                                end else begin
                                    state    <= S_RD;
                                end
                            end
                        end
                    end
                    S_RD: begin
                        // k == nbytes: all addresses issued, last byte arriving now.
                        if (k == nbytes) begin
                            state <= S_DONE;
                            if (own_mem) mem_rdata <= buf_next;
                            else         if_data   <= buf_next;
                        end else begin
                            k <= k + 3'd1;
                            if (k + 3'd1 < nbytes) ram_addr <= ram_addr + 32'd1;
                        end
                    end
                    S_WR: begin
                        if (k + 3'd1 == nbytes) begin
                            ram_wr_q <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            k          <= k + 3'd1;
                            ram_addr   <= ram_addr + 32'd1;
                            ram_dout   <= wdata_rest[7:0];
                            wdata_rest <= {8'd0, wdata_rest[23:8]};
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign ram_wr   = ram_wr_q && rdy;
    assign if_done  = (state == S_DONE) && rdy && !own_mem;
    assign mem_done = (state == S_DONE) && rdy && own_mem;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter. A byte RAM model answers the RAM
// port; directed vectors, starvation, pause/reset sequences and a randomized
// run are checked against a byte-array reference model.
module tb_mem_arbiter;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din = 8'd0;
    logic [31:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic        busy;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr),
        .busy(busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- RAM and reference memory ----------------
    logic [7:0] ram     [logic [31:0]];
    logic [7:0] exp_mem [logic [31:0]];

    function automatic logic [7:0] def_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        ram_din <= ram.exists(ram_addr) ? ram[ram_addr] : def_byte(ram_addr);
        if (ram_wr) ram[ram_addr] = ram_dout;
    end

    function automatic logic [7:0] model_byte(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : def_byte(a);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = model_byte(a + 32'(i));
        return r;
    endfunction

    function automatic int size_bytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a] = b;
        exp_mem[a] = b;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    logic [31:0] addr_log[$];
    logic [31:0] wr_addr_log[$];
    logic [7:0]  wr_byte_log[$];

    // Called #1 after the edge that starts cycle 0, requests already driven.
    // Returns at the negedge of the cycle carrying a done pulse.
    task automatic wait_done(input int pause_at, input int pause_len, input bit rnd_rdy,
                             output int lat, output bit got_if, output bit got_mem);
        lat = -1;
        got_if = 1'b0;
        got_mem = 1'b0;
        addr_log.delete();
        wr_addr_log.delete();
        wr_byte_log.delete();
        for (int c = 0; c < 300; c++) begin
            if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
            else         rdy = !(c >= pause_at && c < pause_at + pause_len);
            @(negedge clk);
            if (c >= 1) addr_log.push_back(ram_addr);
            if (ram_wr) begin
                wr_addr_log.push_back(ram_addr);
                wr_byte_log.push_back(ram_dout);
            end
            if (if_done || mem_done) begin
                lat = c;
                got_if = if_done;
                got_mem = mem_done;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done within 300 cycles, required a done pulse");
        end
    endtask

    typedef struct {
        bit          is_if;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    initial begin
        int lat;
        bit gi, gm;
        logic [31:0] prev_if, prev_mem;

        vecs[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,          32'h0000_0013, 6};
        vecs[1]  = '{1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,          32'h4433_2211, 6};
        vecs[2]  = '{1'b0, 1'b1, 2'b01, 32'h0000_2000, 32'hAABB_CCDD,  32'h0,         3};
        vecs[3]  = '{1'b0, 1'b0, 2'b10, 32'h0000_2000, 32'h0,          32'h0000_CCDD, 6};
        vecs[4]  = '{1'b0, 1'b1, 2'b00, 32'h0000_3000, 32'h1234_5655,  32'h0,         2};
        vecs[5]  = '{1'b0, 1'b0, 2'b01, 32'h0000_3000, 32'h0,          32'h0000_EE55, 4};
        vecs[6]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0100, 32'h0,          32'h0000_0013, 6};
        vecs[7]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0101, 32'h0,          32'h0000_0000, 3};
        vecs[8]  = '{1'b1, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'h0,          32'h5544_3322, 6};
        vecs[9]  = '{1'b0, 1'b1, 2'b10, 32'h0000_2000, 32'h0102_0304,  32'h0,         5};
        vecs[10] = '{1'b1, 1'b0, 2'b10, 32'h0000_2000, 32'h0,          32'h0102_0304, 6};

        preload(32'h100, 8'h13); preload(32'h101, 8'h00);
        preload(32'h102, 8'h00); preload(32'h103, 8'h00);
        preload(32'hFFFF_FFFE, 8'h11); preload(32'hFFFF_FFFF, 8'h22);
        preload(32'h0, 8'h33); preload(32'h1, 8'h44); preload(32'h2, 8'h55);
        for (int i = 0; i < 4; i++) preload(32'h2000 + 32'(i), 8'h00);
        preload(32'h3000, 8'h99); preload(32'h3001, 8'hEE);

        // ---------------- reset ----------------
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ram_addr", ram_addr, 32'd0);
        check("reset_ram_dout", {24'd0, ram_dout}, 32'd0);
        check("reset_if_data", if_data, 32'd0);
        check("reset_mem_rdata", mem_rdata, 32'd0);
        check("reset_flags", {28'd0, ram_wr, if_done, mem_done, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- directed vectors ----------------
        prev_if = 32'd0;
        prev_mem = 32'd0;
        for (int i = 0; i < NV; i++) begin
            vec_t v;
            int n;
            v = vecs[i];
            n = v.is_if ? 4 : size_bytes(v.size);
            if_req = v.is_if; if_addr = v.addr;
            mem_req = !v.is_if; mem_we = v.we; mem_size = v.size;
            mem_addr = v.addr; mem_wdata = v.wdata;
            wait_done(0, 0, 1'b0, lat, gi, gm);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(v.exp_lat));
            check($sformatf("vec%0d_owner", i), {30'd0, gi, gm}, {30'd0, v.is_if, !v.is_if});
            if (!v.is_if && v.we) begin
                check($sformatf("vec%0d_wr_count", i), 32'(wr_addr_log.size()), 32'(n));
                for (int b = 0; b < n && b < wr_addr_log.size(); b++) begin
                    check($sformatf("vec%0d_wr_addr%0d", i, b), wr_addr_log[b], v.addr + 32'(b));
                    check($sformatf("vec%0d_wr_byte%0d", i, b), {24'd0, wr_byte_log[b]},
                          {24'd0, v.wdata[8*b +: 8]});
                    exp_mem[v.addr + 32'(b)] = v.wdata[8*b +: 8];
                end
            end else begin
                check($sformatf("vec%0d_wr_count", i), 32'(wr_addr_log.size()), 32'd0);
                for (int b = 0; b < n && b < addr_log.size(); b++)
                    check($sformatf("vec%0d_rd_addr%0d", i, b), addr_log[b], v.addr + 32'(b));
                if (v.is_if) begin
                    check($sformatf("vec%0d_if_data", i), if_data, v.exp_data);
                    check($sformatf("vec%0d_mem_hold", i), mem_rdata, prev_mem);
                    prev_if = v.exp_data;
                end else begin
                    check($sformatf("vec%0d_mem_rdata", i), mem_rdata, v.exp_data);
                    check($sformatf("vec%0d_if_hold", i), if_data, prev_if);
                    prev_mem = v.exp_data;
                end
            end
            @(posedge clk);
            #1;
            if_req = 1'b0;
            mem_req = 1'b0;
        end

        // ---------------- starvation: both held ----------------
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h2000;
        for (int g = 0; g < 10; g++) begin
            bit want_if;
            want_if = (g % (STARVE_LIMIT + 1)) == STARVE_LIMIT;
            wait_done(0, 0, 1'b0, lat, gi, gm);
            check($sformatf("starve_grant%0d", g), {30'd0, gi, gm}, {30'd0, want_if, !want_if});
            @(posedge clk);
            #1;
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- pause mid word read ----------------
        if_req = 1'b1; if_addr = 32'h100;
        wait_done(2, 3, 1'b0, lat, gi, gm);
        check("pause_latency", 32'(lat), 32'd9);
        check("pause_owner", {30'd0, gi, gm}, 32'd2);
        check("pause_if_data", if_data, 32'h0000_0013);
        @(posedge clk);
        #1;
        if_req = 1'b0;

        // ---------------- reset mid store ----------------
        begin
            bit quiet;
            mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10;
            mem_addr = 32'h5000; mem_wdata = 32'hCAFE_F00D;
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b1;
            mem_req = 1'b0;
            quiet = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (ram_wr || mem_done || if_done || busy) quiet = 1'b0;
                @(posedge clk);
                #1;
            end
            check("post_reset_quiet", {31'd0, quiet}, 32'd1);
            check("post_reset_no_write", {31'd0, ram.exists(32'h5002)}, 32'd0);
        end

        // ---------------- randomized run ----------------
        begin
            bit if_pend, mem_pend, exp_if;
            int starve_m;
            if_pend = 1'b0;
            mem_pend = 1'b0;
            starve_m = 0;
            for (int t = 0; t < 150; t++) begin
                if (!if_pend && $urandom_range(0, 1) == 1) begin
                    if_pend = 1'b1;
                    if_addr = 32'hFFFF_FFE0 + 32'($urandom_range(0, 63));
                end
                if (!mem_pend && ($urandom_range(0, 1) == 1 || !if_pend)) begin
                    mem_pend = 1'b1;
                    mem_we = 1'($urandom_range(0, 1));
                    mem_size = 2'($urandom_range(0, 3));
                    mem_addr = 32'hFFFF_FFE0 + 32'($urandom_range(0, 63));
                    mem_wdata = $urandom;
                end
                if_req = if_pend;
                mem_req = mem_pend;
                exp_if = if_pend && (!mem_pend || starve_m == STARVE_LIMIT);
                wait_done(0, 0, 1'b1, lat, gi, gm);
                if (lat < 0) break;
                check($sformatf("rand%0d_owner", t), {30'd0, gi, gm}, {30'd0, exp_if, !exp_if});
                if (exp_if) begin
                    check($sformatf("rand%0d_if_data", t), if_data, model_read(if_addr, 4));
                    if_pend = 1'b0;
                    starve_m = 0;
                end else begin
                    if (mem_we) begin
                        for (int b = 0; b < size_bytes(mem_size); b++)
                            exp_mem[mem_addr + 32'(b)] = mem_wdata[8*b +: 8];
                    end else begin
                        check($sformatf("rand%0d_mem_rdata", t), mem_rdata,
                              model_read(mem_addr, size_bytes(mem_size)));
                    end
                    if (if_pend) starve_m = (starve_m < STARVE_LIMIT) ? starve_m + 1 : starve_m;
                    else         starve_m = 0;
                    mem_pend = 1'b0;
                end
                @(posedge clk);
                #1;
            end
            if_req = 1'b0;
            mem_req = 1'b0;
            rdy = 1'b1;
            repeat (2) @(posedge clk);
        end

        // ---------------- final memory image ----------------
        foreach (exp_mem[a]) begin
            logic [7:0] got;
            got = ram.exists(a) ? ram[a] : def_byte(a);
            check($sformatf("mem_%h", a), {24'd0, got}, {24'd0, exp_mem[a]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive MEM grants while IF waits.
REQ-002 clk  in  1  clock; all state on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 rdy  in  1  global enable; 0 = pause.
REQ-005 if_req  in  1  instruction fetch request, held until if_done.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_done  out  1  one-cycle fetch completion pulse.
REQ-008 if_data  out  32  fetched word, little-endian.
REQ-009 mem_req  in  1  load/store request, held until mem_done.
REQ-010 mem_we  in  1  1 = store, 0 = load.
REQ-011 mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-012 mem_addr  in  32  load/store byte address.
REQ-013 mem_wdata  in  32  store data, low bytes used.
REQ-014 mem_done  out  1  one-cycle load/store completion pulse.
REQ-015 mem_rdata  out  32  load data, zero-extended raw bytes.
REQ-016 ram_din  in  8  RAM read byte, valid one cycle after ram_addr.
REQ-017 ram_addr  out  32  RAM byte address, registered.
REQ-018 ram_dout  out  8  RAM write byte, registered.
REQ-019 ram_wr  out  1  RAM write strobe.
REQ-020 busy  out  1  high whenever state != IDLE.

Function
REQ-021 States SHALL be IDLE, RD, WR, DONE; requests sampled only in IDLE with rdy=1.
REQ-022 Grant in IDLE: only one req high -> grant it; both high -> grant MEM unless starve_cnt == STARVE_LIMIT, then IF.
REQ-023 starve_cnt SHALL increment (saturating) on a MEM grant with if_req=1, clear on IF grant or MEM grant with if_req=0.
REQ-024 On grant: latch owner, address A, byte count N (IF: 4; MEM: 1/2/4 per mem_size), wdata, direction; clear byte index k; set ram_addr <= A.
REQ-025 Read: RD presents A+k for k=0..N-1, one per cycle; byte on ram_din captured the following cycle into buffer lane k.
REQ-026 Read latency: grant sampled in cycle 0 -> owner done high in cycle N+2, data valid same cycle.
REQ-027 Write: WR drives ram_wr=1, ram_addr=A+k, ram_dout=wdata byte k in cycles 1..N; done high in cycle N+1.
REQ-028 ram_wr SHALL be 0 outside WR and whenever rdy=0.
REQ-029 DONE lasts exactly one cycle, pulses owner's done only, no grant in DONE; IDLE follows.
REQ-030 Owner data output updates only in DONE; otherwise holds previous value; unused upper lanes zero.
REQ-031 Address arithmetic SHALL be 32-bit modulo (0xFFFFFFFF+1 -> 0x00000000).
REQ-032 Request input changes while busy SHALL be ignored; latched copies used.
REQ-033 rdy=0: all state, counters, outputs frozen except in-flight read byte still captured; done outputs forced 0; DONE pulse delivered when rdy returns.

Reset
REQ-034 rst=0 at an edge: state IDLE, starve_cnt 0, k 0, buffers 0; outputs ram_addr, ram_dout, if_data, mem_rdata 0; ram_wr, if_done, mem_done, busy 0.
REQ-035 Reset mid-transfer SHALL abort with no further ram_wr and no done pulse.

Verification
REQ-036 IF only, if_addr=0x100, RAM 0x100..0x103 = 13,00,00,00 -> ram_addr 0x100..0x103 cycles 1..4, if_done cycle 6, if_data=0x00000013.
REQ-037 MEM store half, addr 0x2000, wdata 0xAABBCCDD -> ram_wr cycles 1-2, bytes DD@0x2000, CC@0x2001, mem_done cycle 3, if_done stays 0.
REQ-038 if_req and mem_req held continuously, STARVE_LIMIT=4 -> grant order MEM,MEM,MEM,MEM,IF repeating.
REQ-039 Load word at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001; mem_rdata assembled little-endian.
REQ-040 rdy=0 for 3 cycles mid word read, then rst=0 mid store -> result identical to unpaused read; after reset ram_wr=0, no done, busy=0.
